// File: rtl/rbr_if.sv
// Write port and handshaked read port of the register bank reader.
interface rbr_if #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 3
);
  logic                  rbr_wr;
  logic [ADDR_WIDTH-1:0] rbr_wr_addr;
  logic [DATA_WIDTH-1:0] rbr_in;
  logic                  rbr_rd_req;
  logic [ADDR_WIDTH-1:0] rbr_rd_addr;
  logic                  rbr_rd_busy;
  logic [DATA_WIDTH-1:0] rbr_out;
  logic                  rbr_out_valid;
  logic                  rbr_out_ack;

  modport master (
    output rbr_wr, rbr_wr_addr, rbr_in,
    output rbr_rd_req, rbr_rd_addr, rbr_out_ack,
    input  rbr_rd_busy, rbr_out, rbr_out_valid
  );

  modport slave (
    input  rbr_wr, rbr_wr_addr, rbr_in,
    input  rbr_rd_req, rbr_rd_addr, rbr_out_ack,
    output rbr_rd_busy, rbr_out, rbr_out_valid
  );
endinterface

// File: rtl/reg_bank_reader.sv
// Flop register bank with a registered, held read port.
// RBR_BYPASS_EN: same-address write data forwards into a read capture.
module reg_bank_reader #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 3
) (
  input logic clock,
  input logic rbr_reset,
  rbr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  capture;
  logic                  valid;
  logic                  busy;

  always_ff @(posedge clock) begin
    if (rbr_reset) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    valid      = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rbr_rd_req) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        valid = 1'b1;
        busy  = ~bus.rbr_out_ack;
        if (bus.rbr_out_ack) begin
          capture    = bus.rbr_rd_req;
          next_state = bus.rbr_rd_req ? HOLD : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef RBR_BYPASS_EN
  always_comb begin
    rd_word = mem[bus.rbr_rd_addr];
    if (bus.rbr_wr && bus.rbr_wr_addr == bus.rbr_rd_addr)
      rd_word = bus.rbr_in;
  end
`else
  always_comb begin
    rd_word = mem[bus.rbr_rd_addr];
  end
`endif

  always_ff @(posedge clock) begin
    if (rbr_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.rbr_wr) begin
      mem[bus.rbr_wr_addr] <= bus.rbr_in;
    end
  end

  // Capture is frozen outside an accepted request, so rewrites never leak out.
  always_ff @(posedge clock) begin
    if (rbr_reset)    out_q <= '0;
    else if (capture) out_q <= rd_word;
  end

  assign bus.rbr_out       = out_q;
  assign bus.rbr_out_valid = valid;
  assign bus.rbr_rd_busy   = busy;
endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader with a per-cycle model check.
module tb_reg_bank_reader;
  logic clock = 1'b0;
  logic rbr_reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   run = 1'b0;

  rbr_if #(.DATA_WIDTH(11), .ADDR_WIDTH(3)) bus ();

  reg_bank_reader #(.DATA_WIDTH(11), .ADDR_WIDTH(3)) dut (
    .clock     (clock),
    .rbr_reset (rbr_reset),
    .bus       (bus)
  );

  always #5 clock = ~clock;

`ifdef RBR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [10:0] m_mem [8];
  logic [10:0] m_out;
  logic        m_valid;

  always @(posedge clock) begin
    if (rbr_reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] <= '0;
      m_out   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (bus.rbr_wr) m_mem[bus.rbr_wr_addr] <= bus.rbr_in;
      if (bus.rbr_rd_req && (!m_valid || bus.rbr_out_ack)) begin
        if (BYP && bus.rbr_wr && bus.rbr_wr_addr == bus.rbr_rd_addr)
          m_out <= bus.rbr_in;
        else
          m_out <= m_mem[bus.rbr_rd_addr];
        m_valid <= 1'b1;
      end else if (m_valid && bus.rbr_out_ack) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("valid", 32'(bus.rbr_out_valid), 32'(m_valid));
      chk("busy", 32'(bus.rbr_rd_busy), 32'(m_valid & ~bus.rbr_out_ack));
      if (m_valid) chk("out", 32'(bus.rbr_out), 32'(m_out));
    end
  end

  task automatic step(input bit rst, input bit wr, input int wa,
                      input int din, input bit req, input int ra,
                      input bit ack);
    rbr_reset        = rst;
    bus.rbr_wr       = wr;
    bus.rbr_wr_addr  = 3'(wa);
    bus.rbr_in       = 11'(din);
    bus.rbr_rd_req   = req;
    bus.rbr_rd_addr  = 3'(ra);
    bus.rbr_out_ack  = ack;
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string name, input bit v, input int o,
                     input bit b);
    chk({name, "_v"}, 32'(bus.rbr_out_valid), 32'(v));
    chk({name, "_o"}, 32'(bus.rbr_out), 32'(o));
    chk({name, "_b"}, 32'(bus.rbr_rd_busy), 32'(b));
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    run = 1'b1;
    lit("rst", 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, i, 1);
      lit("rd0", 1, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    lit("rd0_end", 0, 0, 0);

    step(0, 1, 2, 'h5A3, 0, 0, 0);
    lit("wr2", 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0);
    lit("rd2", 1, 'h5A3, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    lit("hold1", 1, 'h5A3, 1);
    step(0, 1, 2, 'h011, 1, 0, 0);
    lit("hold2", 1, 'h5A3, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    lit("hold3", 1, 'h5A3, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    lit("rel", 0, 'h5A3, 0);
    step(0, 0, 0, 0, 1, 2, 0);
    lit("rd2b", 1, 'h011, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    step(0, 1, 5, 'h123, 0, 0, 0);
    step(0, 1, 5, 'h7FF, 1, 5, 0);
    lit("coll", 1, BYP ? 'h7FF : 'h123, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 5, 0);
    lit("rd5", 1, 'h7FF, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    step(0, 1, 1, 'h001, 0, 0, 0);
    step(0, 1, 3, 'h003, 0, 0, 0);
    step(0, 1, 4, 'h004, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1);
    lit("b2b1", 1, 'h001, 0);
    step(0, 0, 0, 0, 1, 3, 1);
    lit("b2b3", 1, 'h003, 0);
    step(0, 0, 0, 0, 1, 4, 1);
    lit("b2b4", 1, 'h004, 0);

    step(1, 1, 6, 'h3AA, 1, 3, 1);
    lit("rsthold", 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, i, 1);
      lit("clr", 1, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    lit("end", 0, 0, 0);

    step(0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
